// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl -- single-transaction HyperBus (HyperRAM) master.
//
// Accepts one 16-bit read or write request at a time from a simple host
// interface and runs it on the HyperBus pins: CS# setup, 6-byte command/address,
// initial latency, two data bytes, CS# hold and a CS#-high recovery gap.
//
// Ports:
//   hbus_clk, hbus_rst      sole clock (rising edge), async active-high reset
//   adr_i, dat_i            byte address and write data, sampled at accept
//   rrq, wrq                read / write request (wrq wins when both are high)
//   ready, busy             idle-and-accepting / transaction in progress
//   dat_o, valid            read data and its one-cycle qualifier
//   err                     one-cycle pulse when read data never arrives
//   hb_cs_n, hb_ck          HyperBus chip select (active low) and clock
//   hb_rwds_o/_oe/_i        RWDS drive, enable, sample
//   hb_dq_o/_oe/_i          DQ[7:0] drive, enable, sample
//
// Build option: define HYPERBUS_VARIABLE_LATENCY_EN to sample RWDS in the
// third command cycle and shorten the latency to 2*LATENCY when it is low.
// Without it the latency is always 4*LATENCY and RWDS is ignored during CA.
module hyperbus_ctrl #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int LATENCY         = 6,
  parameter int RWR_CYCLES      = 4,
  parameter int RD_TIMEOUT      = 64
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] dat_o,
  input  logic                       rrq,
  input  logic                       wrq,
  output logic                       ready,
  output logic                       valid,
  output logic                       busy,
  output logic                       err,
  output logic                       hb_cs_n,
  output logic                       hb_ck,
  output logic                       hb_rwds_o,
  output logic                       hb_rwds_oe,
  input  logic                       hb_rwds_i,
  output logic [7:0]                 hb_dq_o,
  output logic                       hb_dq_oe,
  input  logic [7:0]                 hb_dq_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_CA       = 3'd2;
  localparam logic [2:0] S_LAT      = 3'd3;
  localparam logic [2:0] S_WDATA    = 3'd4;
  localparam logic [2:0] S_RDATA    = 3'd5;
  localparam logic [2:0] S_CS_HOLD  = 3'd6;
  localparam logic [2:0] S_RECOVER  = 3'd7;

  localparam logic [15:0] CA_END       = 16'd5;
  localparam logic [15:0] LAT_LONG_END = 16'(4 * LATENCY - 1);
  localparam logic [15:0] RD_END       = 16'(RD_TIMEOUT - 1);
  localparam logic [15:0] RWR_END      = 16'(RWR_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ck_q, ck_d;
  logic        rd_q, rd_d;
  logic        rbyte_q, rbyte_d;
  logic        rwds_prev_q;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [HBUS_DATA_WIDTH-1:0] dat_q, dat_d;

  // Transaction payload: loaded at accept, never needs a reset value.
  logic [HBUS_ADDR_WIDTH-1:1] adr_q;
  logic [HBUS_DATA_WIDTH-1:0] wdat_q;
  logic [7:0]                 rhi_q;

  logic        accept;
  logic        rwds_edge;
  logic        rd_done;
  logic [15:0] lat_end;
  logic [47:0] ca;
  logic        unused_adr0;

  // Word addressing: byte-address bit 0 never reaches the bus.
  assign unused_adr0 = adr_i[0];

  function automatic logic [47:0] ca_word(input logic rd,
                                          input logic [HBUS_ADDR_WIDTH-1:1] a);
    logic [HBUS_ADDR_WIDTH-1:1] row;
    row = a >> 3;
    ca_word = {rd, 1'b0, 1'b1, 29'(row), 13'd0, a[3:1]};
  endfunction

`ifdef HYPERBUS_VARIABLE_LATENCY_EN
  localparam logic [15:0] LAT_SHORT_END = 16'(2 * LATENCY - 1);
  logic lat_long_q, lat_long_d;
  assign lat_end = lat_long_q ? LAT_LONG_END : LAT_SHORT_END;
`else
  assign lat_end = LAT_LONG_END;
`endif

  assign accept    = (state_q == S_IDLE) && (rrq || wrq);
  assign rwds_edge = hb_rwds_i ^ rwds_prev_q;
  assign rd_done   = rwds_edge && rbyte_q;
  assign ca        = ca_word(rd_q, adr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    ck_d    = 1'b0;
    rd_d    = rd_q;
    rbyte_d = rbyte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
`ifdef HYPERBUS_VARIABLE_LATENCY_EN
    lat_long_d = lat_long_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = S_CS_SETUP;
          rd_d    = ~wrq;
        end
      end
      S_CS_SETUP: begin
        state_d = S_CA;
        cnt_d   = '0;
        ck_d    = 1'b1;
      end
      S_CA: begin
        ck_d = ~ck_q;
`ifdef HYPERBUS_VARIABLE_LATENCY_EN
        if (cnt_q == 16'd2) lat_long_d = hb_rwds_i;
`endif
        if (cnt_q == CA_END) begin
          state_d = S_LAT;
          cnt_d   = '0;
        end
      end
      S_LAT: begin
        ck_d = ~ck_q;
        if (cnt_q == lat_end) begin
          state_d = rd_q ? S_RDATA : S_WDATA;
          cnt_d   = '0;
          rbyte_d = 1'b0;
        end
      end
      S_WDATA: begin
        ck_d = ~ck_q;
        if (cnt_q == 16'd1) begin
          state_d = S_CS_HOLD;
          cnt_d   = '0;
          ck_d    = 1'b0;
        end
      end
      S_RDATA: begin
        ck_d = ~ck_q;
        // A second RWDS transition completes the word even on the last
        // allowed cycle; only otherwise does the timeout fire.
        if (rd_done) begin
          dat_d   = HBUS_DATA_WIDTH'({rhi_q, hb_dq_i});
          valid_d = 1'b1;
          state_d = S_CS_HOLD;
          cnt_d   = '0;
          ck_d    = 1'b0;
        end else begin
          if (rwds_edge) rbyte_d = 1'b1;
          if (cnt_q == RD_END) begin
            err_d   = 1'b1;
            state_d = S_CS_HOLD;
            cnt_d   = '0;
            ck_d    = 1'b0;
          end
        end
      end
      S_CS_HOLD: begin
        state_d = S_RECOVER;
        cnt_d   = '0;
      end
      default: begin
        if (cnt_q == RWR_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ck_q        <= 1'b0;
      rd_q        <= 1'b0;
      rbyte_q     <= 1'b0;
      rwds_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
`ifdef HYPERBUS_VARIABLE_LATENCY_EN
      lat_long_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ck_q        <= ck_d;
      rd_q        <= rd_d;
      rbyte_q     <= rbyte_d;
      rwds_prev_q <= hb_rwds_i;
      valid_q     <= valid_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
`ifdef HYPERBUS_VARIABLE_LATENCY_EN
      lat_long_q  <= lat_long_d;
`endif
    end
  end

  always_ff @(posedge hbus_clk) begin
    if (accept) begin
      adr_q  <= adr_i[HBUS_ADDR_WIDTH-1:1];
      wdat_q <= dat_i;
    end
    if ((state_q == S_RDATA) && rwds_edge && !rbyte_q) rhi_q <= hb_dq_i;
  end

  always_comb begin
    hb_dq_o = 8'd0;
    if (state_q == S_CA) begin
      case (cnt_q[2:0])
        3'd0:    hb_dq_o = ca[47:40];
        3'd1:    hb_dq_o = ca[39:32];
        3'd2:    hb_dq_o = ca[31:24];
        3'd3:    hb_dq_o = ca[23:16];
        3'd4:    hb_dq_o = ca[15:8];
        default: hb_dq_o = ca[7:0];
      endcase
    end else if (state_q == S_WDATA) begin
      hb_dq_o = (cnt_q == 16'd0) ? wdat_q[15:8] : wdat_q[7:0];
    end
  end

  assign hb_cs_n    = (state_q == S_IDLE) || (state_q == S_RECOVER);
  assign hb_ck      = ck_q;
  assign hb_dq_oe   = (state_q == S_CA) || (state_q == S_WDATA);
  assign hb_rwds_oe = (state_q == S_WDATA);
  assign hb_rwds_o  = 1'b0;
  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign valid      = valid_q;
  assign err        = err_q;
  assign dat_o      = dat_q;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Bench for hyperbus_ctrl: a transaction-level model expands each request
// into the expected per-cycle pin/host picture (phase lengths, CA bytes,
// clock parity, data) and a single compare process checks every cycle.
module tb_hyperbus_ctrl;
  localparam int AW   = 32;
  localparam int LAT  = 6;
  localparam int RWR  = 4;
  localparam int RDTO = 64;

  logic          hbus_clk;
  logic          hbus_rst;
  logic [AW-1:0] adr_i;
  logic [15:0]   dat_i;
  logic [15:0]   dat_o;
  logic          rrq, wrq, ready, valid, busy, err;
  logic          hb_cs_n, hb_ck, hb_rwds_o, hb_rwds_oe, hb_rwds_i;
  logic [7:0]    hb_dq_o, hb_dq_i;
  logic          hb_dq_oe;

  hyperbus_ctrl #(
    .HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(16), .LATENCY(LAT),
    .RWR_CYCLES(RWR), .RD_TIMEOUT(RDTO)
  ) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .rrq(rrq), .wrq(wrq), .ready(ready), .valid(valid),
    .busy(busy), .err(err), .hb_cs_n(hb_cs_n), .hb_ck(hb_ck),
    .hb_rwds_o(hb_rwds_o), .hb_rwds_oe(hb_rwds_oe), .hb_rwds_i(hb_rwds_i),
    .hb_dq_o(hb_dq_o), .hb_dq_oe(hb_dq_oe), .hb_dq_i(hb_dq_i)
  );

  initial begin
    hbus_clk = 1'b0;
    forever #5 hbus_clk = ~hbus_clk;
  end

  typedef struct {
    string       ph;
    logic [7:0]  ctl;   // {cs_n, ck, dq_oe, rwds_oe, ready, busy, valid, err}
    logic        dq_chk;
    logic [7:0]  dq;
    logic        rw_chk;
    logic [15:0] dat;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] cur_dat;
  logic [7:0]  obs [0:8];
  int          rd0_cyc = 0, err_cyc = 0, valid_cnt = 0, err_cnt = 0;
  logic [15:0] last_dat = 16'd0;

  // Single per-cycle compare against the model's expected picture.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge hbus_clk);
      cyc++;
      if (valid === 1'b1) begin valid_cnt++; last_dat = dat_o; end
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hb_cs_n, hb_ck, hb_dq_oe, hb_rwds_oe, ready, busy, valid, err};
        n_chk++;
        if (act !== e.ctl || (e.dq_chk && hb_dq_o !== e.dq) ||
            (e.rw_chk && hb_rwds_o !== 1'b0) || dat_o !== e.dat) begin
          n_fail++;
          $display("FAIL %s cycle %0d: got ctl=%b dq=%h rwds_o=%b dat_o=%h, want ctl=%b dq=%h dat_o=%h",
                   e.ph, cyc, act, hb_dq_o, hb_rwds_o, dat_o, e.ctl, e.dq, e.dat);
        end
        if (e.tag >= 1 && e.tag <= 8) obs[e.tag] = hb_dq_o;
        if (e.tag == 10) rd0_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(input string ph, input bit cs_n, input bit ck,
                              input bit dq_oe, input bit [7:0] dq, input bit rwds_oe,
                              input bit rdy, input bit bsy, input bit vld,
                              input bit er, input int tag);
    exp_t e;
    e.ph = ph;
    e.ctl = {cs_n, ck, dq_oe, rwds_oe, rdy, bsy, vld, er};
    e.dq_chk = dq_oe;
    e.dq = dq;
    e.rw_chk = rwds_oe;
    e.dat = cur_dat;
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t idle_rec();
    return mk("idle", 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic exp_t rst_rec();
    exp_t e;
    e = mk("reset", 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    e.dq_chk = 1'b1;
    e.rw_chk = 1'b1;
    return e;
  endfunction

  task automatic tick(input exp_t e);
    exp_q.push_back(e);
    @(posedge hbus_clk);
    #1;
  endtask

  task automatic noise();
    rrq = 1'($urandom);
    wrq = 1'($urandom);
  endtask

  task automatic do_reset();
    hbus_rst = 1'b1;
    #1;
    chk("reset cs_n immediate", 32'(hb_cs_n), 32'd1);
    chk("reset ready immediate", 32'(ready), 32'd1);
    chk("reset busy/ck/oe immediate", {28'd0, busy, hb_ck, hb_dq_oe, hb_rwds_oe}, 32'd0);
    cur_dat = 16'd0;
    tick(rst_rec());
    hbus_rst = 1'b0;
    rrq = 1'b0;
    wrq = 1'b0;
  endtask

  // mode 0: read completes (RWDS toggles at RDATA cycles d1 and d1+1+d2)
  // mode 1: read times out (optional single toggle at d1, -1 for none)
  task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] adr,
                         input logic [15:0] wd, input int mode, input logic [15:0] rdv,
                         input int d1, input int d2, input bit lat_bit, input int rst_at);
    bit is_rd, lvl, vld, er;
    logic [63:0] ca;
    int t, L, last;
    is_rd = do_rd && !do_wr;
    ca = (64'(is_rd) << 47) | (64'd1 << 45) | (64'(adr >> 4) << 16) | 64'((adr >> 1) & 32'd7);
    rrq = do_rd; wrq = do_wr; adr_i = adr; dat_i = wd;
    tick(idle_rec());
    adr_i = $urandom; dat_i = 16'($urandom);
    noise();
    tick(mk("cs_setup", 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    t = 0;
    for (int k = 0; k < 6; k++) begin
      noise();
      hb_rwds_i = (k == 2) ? lat_bit : 1'($urandom);
      hb_dq_i = 8'($urandom);
      tick(mk("ca", 0, (t % 2 == 0), 1, 8'(ca >> (8 * (5 - k))), 0, 0, 1, 0, 0, k + 1));
      t++;
    end
`ifdef HYPERBUS_VARIABLE_LATENCY_EN
    L = lat_bit ? 4 * LAT : 2 * LAT;
`else
    L = 4 * LAT;
`endif
    lvl = 1'($urandom);
    for (int j = 0; j < L; j++) begin
      noise();
      hb_rwds_i = lvl;
      hb_dq_i = 8'($urandom);
      if (j == rst_at) begin
        do_reset();
        return;
      end
      tick(mk("lat", 0, (t % 2 == 0), 0, 8'h00, 0, 0, 1, 0, 0, 0));
      t++;
    end
    vld = 1'b0;
    er = 1'b0;
    if (!is_rd) begin
      for (int k = 0; k < 2; k++) begin
        noise();
        tick(mk("wdata", 0, (t % 2 == 0), 1, (k == 0) ? wd[15:8] : wd[7:0], 1, 0, 1, 0, 0, 7 + k));
        t++;
      end
    end else begin
      last = (mode == 0) ? d1 + 1 + d2 : RDTO - 1;
      for (int j = 0; j <= last; j++) begin
        noise();
        hb_dq_i = 8'($urandom);
        if ((mode == 0 && (j == d1 || j == last)) || (mode == 1 && j == d1)) begin
          lvl = ~lvl;
          hb_dq_i = (j == d1) ? rdv[15:8] : rdv[7:0];
        end
        hb_rwds_i = lvl;
        tick(mk("rdata", 0, (t % 2 == 0), 0, 8'h00, 0, 0, 1, 0, 0, (j == 0) ? 10 : 0));
        t++;
      end
      vld = (mode == 0);
      er = (mode != 0);
      if (vld) cur_dat = rdv;
    end
    noise();
    tick(mk("cs_hold", 0, 0, 0, 8'h00, 0, 0, 1, vld, er, 0));
    for (int k = 0; k < RWR; k++) begin
      noise();
      tick(mk("recover", 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    end
    rrq = 1'b0;
    wrq = 1'b0;
  endtask

  initial begin
    int v0, e0, kind, mode, d1, d2;
    hbus_rst = 1'b1;
    rrq = 1'b0; wrq = 1'b0; adr_i = '0; dat_i = '0;
    hb_rwds_i = 1'b0; hb_dq_i = 8'd0;
    cur_dat = 16'd0;
    @(posedge hbus_clk);
    #1;
    repeat (2) tick(rst_rec());
    hbus_rst = 1'b0;
    repeat (2) tick(idle_rec());

    // Directed write: address 0x104, data 0xA55A.
    run_txn(0, 1, 32'h0000_0104, 16'hA55A, 0, 16'h0, 0, 0, 1'b1, -1);
    tick(idle_rec());
    chk("wr CA byte0", 32'(obs[1]), 32'h20);
    chk("wr CA byte1", 32'(obs[2]), 32'h00);
    chk("wr CA byte2", 32'(obs[3]), 32'h00);
    chk("wr CA byte3", 32'(obs[4]), 32'h10);
    chk("wr CA byte4", 32'(obs[5]), 32'h00);
    chk("wr CA byte5", 32'(obs[6]), 32'h02);
    chk("wr data hi", 32'(obs[7]), 32'hA5);
    chk("wr data lo", 32'(obs[8]), 32'h5A);

    // Directed read returning 0xBEEF.
    v0 = valid_cnt; e0 = err_cnt;
    run_txn(1, 0, 32'h0000_0010, 16'h0, 0, 16'hBEEF, 3, 2, 1'b1, -1);
    tick(idle_rec());
    chk("rd CA byte0", 32'(obs[1]), 32'hA0);
    chk("rd valid pulses", 32'(valid_cnt - v0), 32'd1);
    chk("rd data", 32'(last_dat), 32'h0000_BEEF);
    chk("rd no err", 32'(err_cnt - e0), 32'd0);

    // Read with RWDS never toggling: timeout.
    v0 = valid_cnt; e0 = err_cnt;
    run_txn(1, 0, 32'h0000_0040, 16'h0, 1, 16'h0, -1, 0, 1'b1, -1);
    tick(idle_rec());
    chk("timeout err pulses", 32'(err_cnt - e0), 32'd1);
    chk("timeout err delay", 32'(err_cyc - rd0_cyc), 32'd64);
    chk("timeout no valid", 32'(valid_cnt - v0), 32'd0);

    // rrq and wrq together: a write is performed.
    run_txn(1, 1, 32'h0000_0020, 16'h1234, 0, 16'h0, 0, 0, 1'b1, -1);
    tick(idle_rec());
    chk("both CA byte0 write", 32'(obs[1]), 32'h20);
    chk("both data hi", 32'(obs[7]), 32'h12);

    // Reset in the middle of the latency phase, then an immediate request.
    v0 = valid_cnt; e0 = err_cnt;
    run_txn(1, 0, 32'h0000_0080, 16'h0, 0, 16'h1111, 1, 1, 1'b1, 10);
    repeat (3) tick(idle_rec());
    chk("reset no valid", 32'(valid_cnt - v0), 32'd0);
    chk("reset no err", 32'(err_cnt - e0), 32'd0);
    run_txn(0, 1, 32'h0000_0002, 16'hC3D4, 0, 16'h0, 0, 0, 1'b1, -1);
    chk("post-reset CA byte5", 32'(obs[6]), 32'h01);

    // Randomized mix.
    for (int i = 0; i < 20; i++) begin
      kind = int'($urandom_range(0, 3));
      mode = (kind == 2) ? 1 : 0;
      d1 = int'($urandom_range(0, 20));
      d2 = int'($urandom_range(0, 20));
      if (kind == 2) begin
        if ($urandom_range(0, 1) == 1) d1 = int'($urandom_range(0, RDTO - 1));
        else d1 = -1;
      end
      run_txn(kind != 0, kind == 0 || kind == 3, $urandom, 16'($urandom), mode,
              16'($urandom), d1, d2, 1'($urandom), -1);
      repeat ($urandom_range(0, 2)) tick(idle_rec());
    end
    tick(idle_rec());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
